// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit: stalls the core while a request/acknowledge data-bus access completes
module lsu #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  Funct3,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        Fault,
    output logic        BusReq,
    output logic        BusWe,
    output logic [31:0] BusAddr,
    output logic [31:0] BusWData,
    output logic [3:0]  BusBe,
    input  logic        BusAck,
    input  logic        BusErr,
    input  logic [31:0] BusRData
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUS  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    logic [1:0]  state_q, state_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic [3:0]  be_q, be_d;
    logic [2:0]  f3_q, f3_d;
    logic        we_q, we_d, fault_q, fault_d;
    logic [7:0]  cnt_q, cnt_d;

    logic        access, legal;
    logic [3:0]  be_new;
    logic [31:0] wdata_new, rshift, load_val;
    logic [15:0] half_sel;

    assign access = MemRead | MemWrite;

    always_comb begin
        legal = 1'b0;
        case (Funct3)
            3'b000:         legal = 1'b1;
            3'b001:         legal = ~ALUResult[0];
            3'b010:         legal = (ALUResult[1:0] == 2'b00);
            3'b100, 3'b101: legal = ~MemWrite;
            default:        legal = 1'b0;
        endcase
    end

    // Only B/H/W reach here for stores; loads always fetch the whole word.
    always_comb begin
        be_new    = 4'b1111;
        wdata_new = WriteData;
        if (MemWrite) begin
            case (Funct3[1:0])
                2'b00: begin
                    be_new    = 4'b0001 << ALUResult[1:0];
                    wdata_new = {4{WriteData[7:0]}};
                end
                2'b01: begin
                    be_new    = ALUResult[1] ? 4'b1100 : 4'b0011;
                    wdata_new = {2{WriteData[15:0]}};
                end
                default: begin
                    be_new    = 4'b1111;
                    wdata_new = WriteData;
                end
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        be_d    = be_q;
        f3_d    = f3_q;
        we_d    = we_q;
        fault_d = fault_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (access && legal) begin
                    state_d = S_BUS;
                    addr_d  = {ALUResult[31:2], 2'b00} | {30'd0, ALUResult[1:0]};
                    wdata_d = wdata_new;
                    be_d    = be_new;
                    f3_d    = Funct3;
                    we_d    = MemWrite;
                    fault_d = 1'b0;
                    rdata_d = 32'd0;
                    cnt_d   = 8'd0;
                end
            end
            S_BUS: begin
                cnt_d = cnt_q + 8'd1;
                if (BusErr) begin
                    state_d = S_DONE;
                    fault_d = 1'b1;
                end else if (BusAck) begin
                    state_d = S_DONE;
                    rdata_d = BusRData;
                end else if (cnt_q == TMO_LAST) begin
                    state_d = S_DONE;
                    fault_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            be_q    <= 4'd0;
            f3_q    <= 3'd0;
            we_q    <= 1'b0;
            fault_q <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            be_q    <= be_d;
            f3_q    <= f3_d;
            we_q    <= we_d;
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rshift   = rdata_q >> {addr_q[1:0], 3'b000};
    assign half_sel = addr_q[1] ? rdata_q[31:16] : rdata_q[15:0];

    always_comb begin
        case (f3_q)
            3'b000:  load_val = {{24{rshift[7]}}, rshift[7:0]};
            3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_val = {24'd0, rshift[7:0]};
            3'b101:  load_val = {16'd0, half_sel};
            default: load_val = rdata_q;
        endcase
    end

    always_comb begin
        ReadData = 32'd0;
        Stall    = 1'b0;
        Fault    = 1'b0;
        BusReq   = 1'b0;
        BusWe    = 1'b0;
        BusAddr  = 32'd0;
        BusWData = 32'd0;
        BusBe    = 4'd0;
        case (state_q)
            S_IDLE: begin
                Stall = access & legal;
                Fault = access & ~legal;
            end
            S_BUS: begin
                Stall    = 1'b1;
                BusReq   = 1'b1;
                BusWe    = we_q;
                BusAddr  = {addr_q[31:2], 2'b00};
                BusWData = wdata_q;
                BusBe    = be_q;
            end
            S_DONE: begin
                Fault    = fault_q;
                ReadData = (we_q || fault_q) ? 32'd0 : load_val;
            end
            default: ;
        endcase
    end
endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store unit sitting directly downstream of the core datapath.
- Takes the datapath's ALUResult (address), WriteData and memory controls, and runs a request/acknowledge transaction on an external data bus.
- Returns sign- or zero-extended ReadData to the result mux.
- Stalls the core (PC and register-file write held) until the access completes, so memory latency may be variable.

Parameters:
- TIMEOUT, 16, max cycles spent in BUS waiting for BusAck/BusErr before the access is aborted with Fault (range 1-255).

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- MemRead  input  1  current instruction is a load
- MemWrite  input  1  current instruction is a store; wins over MemRead if both are high
- Funct3  input  3  access type: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only)
- ALUResult  input  32  byte address
- WriteData  input  32  store data (rs2)
- ReadData  output  32  extended load data, valid in DONE
- Stall  output  1  core must hold PC and suppress RegWrite
- Fault  output  1  single-cycle access fault pulse
- BusReq  output  1  bus request
- BusWe  output  1  1 = write
- BusAddr  output  32  word-aligned address ({ALUResult[31:2],2'b00})
- BusWData  output  32  lane-replicated store data
- BusBe  output  4  byte enables
- BusAck  input  1  transfer complete; BusRData valid this cycle
- BusErr  input  1  transfer failed
- BusRData  input  32  read data word

Behaviour:
- Reset (asynchronous, reset=0):
  - state=IDLE; all outputs 0; captured address/data/BE/Funct3/rdata and timeout counter cleared.
  - BusReq drops immediately, including mid-transaction; no ack is awaited after reset.
- FSM states: IDLE, BUS, DONE.
- IDLE, no access (MemRead=MemWrite=0): Stall=0, Fault=0.
- IDLE, access legal (aligned, legal Funct3): Stall=1 combinationally; capture inputs and go to BUS at next edge.
- IDLE, access illegal:
  - Illegal means H with addr[0]=1, W with addr[1:0]!=0, Funct3 in {011,110,111}, or store with 100/101.
  - Fault=1 and Stall=0 combinationally, ReadData=0, no bus transaction; the instruction retires with no memory side effect.
- BUS:
  - BusReq=1 with BusWe/BusAddr/BusWData/BusBe driven from captured registers, held stable until termination. Stall=1. Counter increments each cycle.
  - On BusErr: go to DONE with fault flag. BusErr beats BusAck if both are high.
  - Else on BusAck: capture BusRData, go to DONE.
  - Else, if counter reaches TIMEOUT-1: go to DONE with fault flag.
- DONE (exactly one cycle):
  - BusReq=0, Stall=0. ReadData = extended captured data for loads, 0 for stores or faulted accesses. Fault = fault flag.
  - Unconditional return to IDLE; the core advances PC on this edge.
- Minimum memory-instruction latency is 3 cycles (IDLE, BUS with same-cycle ack, DONE).
- BusAck/BusErr while BusReq=0 are ignored.
- Store lanes:
  - SB: BusBe = 4'b0001<<addr[1:0]; BusWData = {4{WriteData[7:0]}}.
  - SH: BusBe = addr[1] ? 4'b1100 : 4'b0011; BusWData = {2{WriteData[15:0]}}.
  - SW: BusBe = 4'b1111; BusWData = WriteData.
- Loads: BusBe = 4'b1111. Byte/half selected by captured addr[1:0], sign-extended (B, H) or zero-extended (BU, HU).
- Inputs are sampled only in IDLE; changes during BUS have no effect.

Test Plan:
- LW to 0x100, BusAck on first BUS cycle with BusRData=0xDEADBEEF -> Stall high 2 cycles, DONE ReadData=0xDEADBEEF, BusBe=1111, BusAddr=0x100, Fault=0.
- LB addr 0x203 / LBU addr 0x203 with BusRData=0x80112233 -> ReadData=0xFFFFFF80 / 0x00000080.
- SH addr 0x302, WriteData=0x0000ABCD, ack after 3 wait cycles -> BusBe=1100, BusWData=0xABCDABCD, BusWe=1, BusReq held 4 cycles, Stall high 5 cycles total.
- LW addr 0x101 -> Fault=1 same cycle, Stall=0, BusReq never asserted; SB Funct3=100 -> same.
- TIMEOUT=4, no ack -> BusReq high exactly 4 cycles, then DONE with Fault=1, ReadData=0. Separately, BusAck+BusErr same cycle -> Fault=1.
- Assert reset low on the second BUS cycle -> BusReq=0 immediately, state IDLE; after release, a new SW completes normally.
